// File: rtl/fifo_ctrl_sync.sv
// Synchronous FIFO controller: pointers, occupancy, status flags and memory enables.
// Define FIFO_CTRL_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module fifo_ctrl_sync #(
    parameter int ASIZE     = 4,
    parameter int AFULL_TH  = (1 << ASIZE) - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_req,
    input  logic             rd_req,
    input  logic             err_clr,
    output logic             wen,
    output logic             ren,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE-1:0] raddr,
    output logic             rvalid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_C = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AF_C    = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0] AE_C    = (ASIZE+1)'(AEMPTY_TH);
    localparam logic [ASIZE:0] PTR_ONE = {{ASIZE{1'b0}}, 1'b1};

    logic [ASIZE:0] wptr;
    logic [ASIZE:0] rptr;

    // The extra pointer bit separates full from empty when the addresses match.
    assign count        = wptr - rptr;
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);
    assign waddr        = wptr[ASIZE-1:0];
    assign raddr        = rptr[ASIZE-1:0];

    // Gating with rst_n keeps the memory quiet while reset is held.
    assign wen = wr_req & ~full & rst_n;
    assign ren = rd_req & ~empty & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr   <= '0;
            rptr   <= '0;
            rvalid <= 1'b0;
        end else begin
            if (wen) begin
                wptr <= wptr + PTR_ONE;
            end
            if (ren) begin
                rptr <= rptr + PTR_ONE;
            end
            rvalid <= ren;
        end
    end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    // A new error in the same cycle as err_clr takes priority over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_req && full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_req && empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl_sync.sv
// Bench for fifo_ctrl_sync (ASIZE=4, default thresholds): vector table plus
// hand-written reset and error-flag sequences; rvalid tracked by a scoreboard.
module tb_fifo_ctrl_sync;

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       wr_req;
    logic       rd_req;
    logic       err_clr;
    logic       wen;
    logic       ren;
    logic [3:0] waddr;
    logic [3:0] raddr;
    logic       rvalid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit wr;
        bit rd;
        bit clr;
        bit wen;
        bit ren;
        int cnt;
        int wa;
        int ra;
        bit full;
        bit empty;
        bit af;
        bit ae;
        bit ov;
        bit un;
    } vec_t;

    vec_t tbl[$];
    int   sb[$];

    fifo_ctrl_sync #(.ASIZE(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .err_clr      (err_clr),
        .wen          (wen),
        .ren          (ren),
        .waddr        (waddr),
        .raddr        (raddr),
        .rvalid       (rvalid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%0d required=%0d", name, id, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit wr, input bit rd, input bit clr, input bit e_wen,
                                input bit e_ren, input int cnt, input int wa, input int ra,
                                input bit ov, input bit un);
        vec_t v;
        v.wr = wr;  v.rd = rd;  v.clr = clr;
        v.wen = e_wen;  v.ren = e_ren;
        v.cnt = cnt;  v.wa = wa;  v.ra = ra;
        v.full  = (cnt == 16);
        v.empty = (cnt == 0);
        v.af    = (cnt >= 14);
        v.ae    = (cnt <= 2);
        v.ov = ov;  v.un = un;
        return v;
    endfunction

    // Drive one cycle of requests, compare before the edge, then clock it.
    task automatic apply(input vec_t v, input int id);
        bit exp_rv;
        wr_req  = v.wr;
        rd_req  = v.rd;
        err_clr = v.clr;
        @(negedge clk);
        exp_rv = 1'b0;
        if (sb.size() > 0) begin
            void'(sb.pop_front());
            exp_rv = 1'b1;
        end
        chk("rvalid", id, 32'(rvalid), 32'(exp_rv));
        chk("wen", id, 32'(wen), 32'(v.wen));
        chk("ren", id, 32'(ren), 32'(v.ren));
        chk("count", id, 32'(count), v.cnt);
        chk("full", id, 32'(full), 32'(v.full));
        chk("empty", id, 32'(empty), 32'(v.empty));
        chk("almost_full", id, 32'(almost_full), 32'(v.af));
        chk("almost_empty", id, 32'(almost_empty), 32'(v.ae));
        chk("waddr", id, 32'(waddr), v.wa);
        chk("raddr", id, 32'(raddr), v.ra);
        chk("overflow", id, 32'(overflow), 32'(v.ov));
        chk("underflow", id, 32'(underflow), 32'(v.un));
        if (v.ren) sb.push_back(v.ra);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 16 writes from reset; almost_full from count 14, waddr wraps to 0
        for (int i = 0; i < 16; i++) tbl.push_back(mk(1, 0, 0, 1, 0, i, i, 0, 0, 0));
        // 17th write while full is refused
        tbl.push_back(mk(1, 0, 0, 0, 0, 16, 0, 0, 0, 0));
        // 16 reads drain the FIFO, raddr wraps to 0
        for (int i = 0; i < 16; i++) tbl.push_back(mk(0, 1, 0, 0, 1, 16 - i, 0, i, ERR, 0));
        // both requests at count 0: write only
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, ERR, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 0, 0, 1, 0, 1 + i, 1 + i, 0, ERR, ERR));
        // both requests at count 5: both accepted
        tbl.push_back(mk(1, 1, 0, 1, 1, 5, 5, 0, ERR, ERR));
        for (int i = 0; i < 11; i++) tbl.push_back(mk(1, 0, 0, 1, 0, 5 + i, (6 + i) % 16, 1, ERR, ERR));
        // both requests at count 16: read only
        tbl.push_back(mk(1, 1, 0, 0, 1, 16, 1, 1, ERR, ERR));
        tbl.push_back(mk(0, 0, 0, 0, 0, 15, 1, 2, ERR, ERR));

        // Reset held with requests high
        rst_n = 1'b0; wr_req = 1'b1; rd_req = 1'b1; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 0, 32'(count), 0);
        chk("rst_empty", 0, 32'(empty), 1);
        chk("rst_full", 0, 32'(full), 0);
        chk("rst_aempty", 0, 32'(almost_empty), 1);
        chk("rst_afull", 0, 32'(almost_full), 0);
        chk("rst_wen", 0, 32'(wen), 0);
        chk("rst_ren", 0, 32'(ren), 0);
        chk("rst_waddr", 0, 32'(waddr), 0);
        chk("rst_raddr", 0, 32'(raddr), 0);
        chk("rst_rvalid", 0, 32'(rvalid), 0);
        chk("rst_ovf", 0, 32'(overflow), 0);
        chk("rst_unf", 0, 32'(underflow), 0);
        wr_req = 1'b0; rd_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Async reset at count 7 with a read in flight
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) apply(mk(1, 0, 0, 1, 0, i, i, 0, 0, 0), 100 + i);
        apply(mk(0, 1, 0, 0, 1, 8, 8, 0, 0, 0), 108);
        chk("inflight_rvalid", 0, 32'(rvalid), 1);
        chk("inflight_count", 0, 32'(count), 7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 0, 32'(count), 0);
        chk("arst_empty", 0, 32'(empty), 1);
        chk("arst_rvalid", 0, 32'(rvalid), 0);
        chk("arst_waddr", 0, 32'(waddr), 0);
        chk("arst_raddr", 0, 32'(raddr), 0);
        sb.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Underflow sticky, err_clr clears, set wins over clear
        apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 200);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ERR), 201);
        apply(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, ERR), 202);
        apply(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 203);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ERR), 204);
        apply(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, ERR), 205);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 206);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
